// File: rtl/logic_op_scheduler_pkg.sv
// Shared definitions for the bit-serial logic-op scheduler:
// op code values, FSM state encoding and the default operand width.
package logic_op_scheduler_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [2:0] OP_NAND  = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_NOR   = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_NOTA  = 3'd6;
    localparam logic [2:0] OP_NOTA2 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit_1b.sv
// One-bit eight-way logic function, selected by op.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state is held.
module logic_unit_1b
    import logic_op_scheduler_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic [2:0] i_op,
    output logic       o_f
);

    always_comb begin
        o_f = 1'b0;
        case (i_op)
            OP_NAND:  o_f = ~(i_a & i_b);
            OP_AND:   o_f = i_a & i_b;
            OP_OR:    o_f = i_a | i_b;
            OP_NOR:   o_f = ~(i_a | i_b);
            OP_XOR:   o_f = i_a ^ i_b;
            OP_XNOR:  o_f = ~(i_a ^ i_b);
            OP_NOTA:  o_f = ~i_a;
            OP_NOTA2: o_f = ~i_a;
            default:  o_f = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// Two-requester arbiter feeding a bit-serial logic unit, one bit per cycle, LSB first.
// Latency: rsp_valid rises WIDTH+1 edges after the request handshake edge.
// Backpressure: result held while rsp_ready is low; requesters held off until the result is taken.
module logic_op_scheduler
    import logic_op_scheduler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_id;
    logic             r_last_grant;
    logic             r_rsp_valid;

    logic             w_grant_vld;
    logic             w_grant_id;
    logic             w_rsp_hs;
    logic             w_bit;

    assign w_rsp_hs = r_rsp_valid & rsp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_vld)         w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_cnt == CNT_LAST)   w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_hs)            w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: a tie goes to whichever requester was not served last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (rst_n && (r_state == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ~r_last_grant;
            end else if (req0_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b0;
            end else if (req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b1;
            end
        end
        req0_ready = w_grant_vld & ~w_grant_id;
        req1_ready = w_grant_vld &  w_grant_id;
    end

    logic_unit_1b u_logic_unit (
        .i_a  (r_a[r_cnt]),
        .i_b  (r_b[r_cnt]),
        .i_op (r_op),
        .o_f  (w_bit)
    );

    // Operands are captured at the handshake so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_result     <= '0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_a          <= w_grant_id ? req1_a  : req0_a;
                        r_b          <= w_grant_id ? req1_b  : req0_b;
                        r_op         <= w_grant_id ? req1_op : req0_op;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_cnt        <= '0;
                        r_result     <= '0;
                    end
                end
                ST_EXEC: begin
                    r_result[r_cnt] <= w_bit;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // One settling cycle in RESP before the result is presented.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_result;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Bench for logic_op_scheduler at WIDTH=4: timestamp-based reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_logic_op_scheduler;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
    } rsp_t;
    rsp_t rsp_q[$];

    logic_op_scheduler #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] op_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return ~(a & b);
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            default: return ~a;
        endcase
    endfunction

    // Reference model: busy flag plus the edge on which the current op was accepted.
    logic         m_busy = 1'b0;
    logic         m_last = 1'b1;
    logic         m_id   = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_tacc = 0;

    always @(negedge clk) begin
        logic e0, e1, ev;
        e0 = rst_n && !m_busy && req0_valid && (!req1_valid || m_last);
        e1 = rst_n && !m_busy && req1_valid && (!req0_valid || !m_last);
        ev = m_busy && (cyc >= m_tacc + W + 1);
        check("model_req0_ready", req0_ready, e0);
        check("model_req1_ready", req1_ready, e1);
        check("model_rsp_valid",  rsp_valid,  ev);
        if (ev) begin
            check("model_rsp_data", rsp_data, m_data);
            check("model_rsp_id",   rsp_id,   m_id);
        end
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (e0 || e1) begin
            m_busy = 1'b1;
            m_id   = e1;
            m_last = e1;
            m_tacc = cyc + 1;
            m_data = e1 ? op_ref(req1_a, req1_b, req1_op) : op_ref(req0_a, req0_b, req0_op);
        end else if (ev && rsp_ready) begin
            m_busy = 1'b0;
        end
    end

    // Issue one op and wait for its result; lat = edges from handshake to rsp_valid visible.
    task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input bit flip,
                         output logic [W-1:0] data, output logic rid, output int lat);
        bit hs;
        int k;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        hs = 1'b0;
        k  = 0;
        while (!hs && k < 50) begin
            @(negedge clk);
            hs = id ? req1_ready : req0_ready;
            @(posedge clk); #1;
            k++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (flip) begin
            req0_a = ~req0_a; req0_b = ~req0_b; req0_op = ~req0_op;
        end
        lat  = -1;
        data = '0;
        rid  = 1'b0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat  = j;
                data = rsp_data;
                rid  = rsp_id;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Hold requester valids until each is accepted, logging every consumed response.
    task automatic run_cycles(input int n);
        bit a0, a1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            if (rsp_valid && rsp_ready) rsp_q.push_back('{id: rsp_id, data: rsp_data});
            @(posedge clk); #1;
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
        end
    endtask

    task automatic set_tie();
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 4'b1111; req0_b = 4'b1111;
        req1_valid = 1'b1; req1_op = 3'd2; req1_a = 4'b0000; req1_b = 4'b0001;
    endtask

    task automatic check_pair(input string name, input logic id0, input logic [W-1:0] d0,
                              input logic id1, input logic [W-1:0] d1);
        check({name, "_count"}, rsp_q.size(), 2);
        if (rsp_q.size() >= 2) begin
            check({name, "_id0"},   rsp_q[0].id,   id0);
            check({name, "_data0"}, rsp_q[0].data, d0);
            check({name, "_id1"},   rsp_q[1].id,   id1);
            check({name, "_data1"}, rsp_q[1].data, d1);
        end
    endtask

    logic [W-1:0] sweep_exp [8] = '{4'b0111, 4'b1000, 4'b1110, 4'b0001,
                                    4'b0110, 4'b1001, 4'b0011, 4'b0011};

    initial begin
        logic [W-1:0] d;
        logic         rid;
        int           lat;
        bit           hs;

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_tie();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_rsp_valid",  rsp_valid,  1'b0);
        check("reset_rsp_data",   rsp_data,   4'b0000);
        check("reset_rsp_id",     rsp_id,     1'b0);
        check("reset_req0_ready", req0_ready, 1'b0);
        check("reset_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First tie after reset goes to requester 0.
        rsp_q.delete();
        run_cycles(20);
        check_pair("tie_after_reset", 1'b0, 4'b1111, 1'b1, 4'b0001);

        do_op(1'b0, 4'b1100, 4'b1010, 3'd4, 1'b0, d, rid, lat);
        check("single_data", d,   4'b0110);
        check("single_id",   rid, 1'b0);
        check("single_lat",  lat, 5);

        // Requester 0 was served last, so this tie goes to requester 1.
        set_tie();
        rsp_q.delete();
        run_cycles(20);
        check_pair("tie_alternate", 1'b1, 4'b0001, 1'b0, 4'b1111);

        for (int op = 0; op < 8; op++) begin
            do_op(1'b0, 4'b1100, 4'b1010, 3'(op), 1'b0, d, rid, lat);
            check($sformatf("sweep_op%0d_data", op), d, sweep_exp[op]);
            check($sformatf("sweep_op%0d_lat", op),  lat, 5);
        end

        do_op(1'b1, 4'b0110, 4'b0101, 3'd7, 1'b0, d, rid, lat);
        check("req1_nota_data", d,   4'b1001);
        check("req1_nota_id",   rid, 1'b1);

        // Backpressure with requester 1 waiting.
        rsp_ready = 1'b0;
        do_op(1'b0, 4'b1100, 4'b1010, 3'd1, 1'b0, d, rid, lat);
        check("bp_data", d, 4'b1000);
        req1_valid = 1'b1; req1_op = 3'd2; req1_a = 4'b0000; req1_b = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid,  1'b1);
            check("bp_hold_data",  rsp_data,   4'b1000);
            check("bp_hold_id",    rsp_id,     1'b0);
            check("bp_hold_r0",    req0_ready, 1'b0);
            check("bp_hold_r1",    req1_ready, 1'b0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", rsp_valid,  1'b1);
        check("bp_release_r1",    req1_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_valid", rsp_valid,  1'b0);
        check("bp_idle_r1",    req1_ready, 1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rsp_q.delete();
        run_cycles(10);
        check("bp_next_count", rsp_q.size(), 1);
        if (rsp_q.size() >= 1) begin
            check("bp_next_id",   rsp_q[0].id,   1'b1);
            check("bp_next_data", rsp_q[0].data, 4'b0001);
        end

        // Captured operands survive input changes during EXEC.
        do_op(1'b0, 4'b1100, 4'b1010, 3'd4, 1'b1, d, rid, lat);
        check("opchg_data", d, 4'b0110);

        // Reset while bit 2 of 4 is being evaluated.
        req0_valid = 1'b1; req0_a = 4'b0101; req0_b = 4'b0011; req0_op = 3'd4;
        hs = 1'b0;
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge clk);
            hs = req0_ready;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        set_tie();
        @(negedge clk);
        check("midrst_r0_low", req0_ready, 1'b0);
        check("midrst_r1_low", req1_ready, 1'b0);
        @(posedge clk); #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_rsp_data",  rsp_data,  4'b0000);
        check("midrst_rsp_id",    rsp_id,    1'b0);
        rst_n = 1'b1;
        rsp_q.delete();
        run_cycles(20);
        check_pair("tie_after_midrst", 1'b0, 4'b1111, 1'b1, 4'b0001);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 100000", $time);
        $fatal(1);
    end

endmodule
